abr_prim_alert_tx: RTL and testbench



---
 rtl/abr_prim_alert_pkg.sv | 17 +
 rtl/abr_prim_alert_tx.sv | 133 +++++++++++++
 tb/tb_abr_prim_alert_tx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/abr_prim_alert_pkg.sv
// rtl/abr_prim_alert_pkg.sv - shared types and reset levels for the alert transmitter
package abr_prim_alert_pkg;

  // Encodings are fixed so formal property files can refer to them directly.
  typedef enum logic [2:0] {
    Idle   = 3'b000,
    HsPh1  = 3'b001,
    HsPh2  = 3'b010,
    Pause0 = 3'b011,
    Pause1 = 3'b100,
    SigInt = 3'b101
  } alert_tx_state_e;

  localparam logic ALERT_P_RST = 1'b0;
  localparam logic ALERT_N_RST = 1'b1;

endpackage

// File: rtl/abr_prim_alert_tx.sv
// rtl/abr_prim_alert_tx.sv - differential alert transmitter with 4-phase handshake and ping response
module abr_prim_alert_tx
  import abr_prim_alert_pkg::*;
#(
  parameter bit IsFatal = 1'b0,
  parameter bit PingOn  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic alert_req_i,
  input  logic alert_test_i,
  output logic alert_ack_o,
  output logic alert_pending_o,
  input  logic ping_event_i,
  input  logic ping_sigint_i,
  input  logic ack_level_i,
  input  logic ack_sigint_i,
  output logic alert_p_o,
  output logic alert_n_o,
  output logic integ_fail_o
);

  alert_tx_state_e state_q, state_d;
  logic alert_pend, ping_pend;
  logic serve_alert, serve_ping;
  logic alert_rearm, ping_rearm;
  logic fatal_q, ack_due;
  logic sigint, alert_set, ping_set, hs_start, hs_done;

  assign sigint    = ack_sigint_i | (PingOn & ping_sigint_i);
  assign alert_set = alert_req_i | alert_test_i;
  assign ping_set  = PingOn & ping_event_i;
  assign hs_start  = (state_q == Idle) && (state_d == HsPh1);
  assign alert_pending_o = alert_pend;

  always_comb begin
    state_d = state_q;
    hs_done = 1'b0;
    if (sigint) begin
      state_d = SigInt;
    end else begin
      case (state_q)
        Idle:    if (alert_pend | ping_pend) state_d = HsPh1;
        HsPh1:   if (ack_level_i) state_d = HsPh2;
        HsPh2: begin
          if (!ack_level_i) begin
            state_d = Pause0;
            hs_done = 1'b1;
          end
        end
        Pause0:  state_d = Pause1;
        Pause1:  state_d = Idle;
        SigInt:  state_d = Pause0;
        default: state_d = Idle;
      endcase
    end
  end

  // A request landing while its own flag is being served must survive the
  // clear at handshake end, so it is remembered in the rearm flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= Idle;
      alert_pend   <= 1'b0;
      ping_pend    <= 1'b0;
      serve_alert  <= 1'b0;
      serve_ping   <= 1'b0;
      alert_rearm  <= 1'b0;
      ping_rearm   <= 1'b0;
      fatal_q      <= 1'b0;
      ack_due      <= 1'b0;
      alert_ack_o  <= 1'b0;
      alert_p_o    <= ALERT_P_RST;
      alert_n_o    <= ALERT_N_RST;
      integ_fail_o <= 1'b0;
    end else begin
      state_q <= state_d;

      if (hs_start) begin
        serve_alert <= alert_pend;
        serve_ping  <= ping_pend;
      end else if (hs_done || state_d == SigInt) begin
        serve_alert <= 1'b0;
        serve_ping  <= 1'b0;
      end

      if (hs_done || state_d == SigInt) begin
        alert_rearm <= 1'b0;
        ping_rearm  <= 1'b0;
      end else begin
        if ((serve_alert || (hs_start && alert_pend)) && alert_set) alert_rearm <= 1'b1;
        if ((serve_ping || (hs_start && ping_pend)) && ping_set) ping_rearm <= 1'b1;
      end

      fatal_q    <= fatal_q | (IsFatal & alert_req_i);
      alert_pend <= (alert_pend & ~(hs_done & serve_alert & ~alert_rearm & ~fatal_q)) | alert_set;
      ping_pend  <= (ping_pend & ~(hs_done & serve_ping & ~ping_rearm)) | ping_set;

      ack_due     <= hs_done & serve_alert;
      alert_ack_o <= ack_due;

      integ_fail_o <= (state_q == SigInt);
      case (state_q)
        HsPh1: begin
          alert_p_o <= 1'b1;
          alert_n_o <= 1'b0;
        end
        SigInt: begin
          if (alert_p_o ^ alert_n_o) begin
            alert_p_o <= 1'b1;
            alert_n_o <= 1'b1;
          end else begin
            alert_p_o <= ~alert_p_o;
            alert_n_o <= ~alert_p_o;
          end
        end
        default: begin
          alert_p_o <= ALERT_P_RST;
          alert_n_o <= ALERT_N_RST;
        end
      endcase
    end
  end

  // The pair output lags the state by one cycle, as does integ_fail_o.
  a_pair_diff: assert property (@(posedge clk_i) disable iff (rst_i)
    !integ_fail_o |-> (alert_p_o ^ alert_n_o));
  a_ack_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
    alert_ack_o |=> !alert_ack_o);
  a_ack_src: assert property (@(posedge clk_i) disable iff (rst_i)
    alert_ack_o |-> ($past(state_q, 2) == HsPh2));

endmodule

// File: tb/tb_abr_prim_alert_tx.sv
// tb/tb_abr_prim_alert_tx.sv - directed self-checking bench for abr_prim_alert_tx
module tb_abr_prim_alert_tx;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic alert_req = 1'b0, alert_test = 1'b0;
  logic ping_event = 1'b0, ping_sigint = 1'b0;
  logic ack_level = 1'b0, ack_sigint = 1'b0;
  logic [2:0] ack_o, pend_o, p_o, n_o, integ_o;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  // index 0: default, 1: IsFatal, 2: PingOn off
  abr_prim_alert_tx #(.IsFatal(1'b0), .PingOn(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .alert_req_i(alert_req), .alert_test_i(alert_test),
    .alert_ack_o(ack_o[0]), .alert_pending_o(pend_o[0]), .ping_event_i(ping_event),
    .ping_sigint_i(ping_sigint), .ack_level_i(ack_level), .ack_sigint_i(ack_sigint),
    .alert_p_o(p_o[0]), .alert_n_o(n_o[0]), .integ_fail_o(integ_o[0]));

  abr_prim_alert_tx #(.IsFatal(1'b1), .PingOn(1'b1)) dut_f (
    .clk_i(clk_i), .rst_i(rst_i), .alert_req_i(alert_req), .alert_test_i(alert_test),
    .alert_ack_o(ack_o[1]), .alert_pending_o(pend_o[1]), .ping_event_i(ping_event),
    .ping_sigint_i(ping_sigint), .ack_level_i(ack_level), .ack_sigint_i(ack_sigint),
    .alert_p_o(p_o[1]), .alert_n_o(n_o[1]), .integ_fail_o(integ_o[1]));

  abr_prim_alert_tx #(.IsFatal(1'b0), .PingOn(1'b0)) dut_np (
    .clk_i(clk_i), .rst_i(rst_i), .alert_req_i(alert_req), .alert_test_i(alert_test),
    .alert_ack_o(ack_o[2]), .alert_pending_o(pend_o[2]), .ping_event_i(ping_event),
    .ping_sigint_i(ping_sigint), .ack_level_i(ack_level), .ack_sigint_i(ack_sigint),
    .alert_p_o(p_o[2]), .alert_n_o(n_o[2]), .integ_fail_o(integ_o[2]));

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    alert_req = 0; alert_test = 0; ping_event = 0; ping_sigint = 0;
    ack_level = 0; ack_sigint = 0;
    rst_i = 1;
    step(); step();
    rst_i = 0;
    step();
  endtask

  initial begin
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk2("rst_pair", {p_o[i], n_o[i]}, 2'b01);
      chk1("rst_ack", ack_o[i], 1'b0);
      chk1("rst_pend", pend_o[i], 1'b0);
      chk1("rst_integ", integ_o[i], 1'b0);
    end

    // Single alert on the default instance
    alert_req = 1; step(); alert_req = 0;             // E0
    chk1("s1_pend_set", pend_o[0], 1'b1);
    step();                                           // E1
    chk2("s1_pair_e1", {p_o[0], n_o[0]}, 2'b01);
    step();                                           // E2
    chk2("s1_pair_e2", {p_o[0], n_o[0]}, 2'b10);
    step(); step();                                   // E3, E4
    ack_level = 1; step();                            // E5
    chk2("s1_pair_e5", {p_o[0], n_o[0]}, 2'b10);
    step();                                           // E6
    chk2("s1_pair_e6", {p_o[0], n_o[0]}, 2'b01);
    step(); ack_level = 0; step();                    // E7, E8
    chk1("s1_ack_e8", ack_o[0], 1'b0);
    step();                                           // E9
    chk1("s1_ack_e9", ack_o[0], 1'b1);
    chk1("s1_pend_e9", pend_o[0], 1'b0);
    step();                                           // E10
    chk1("s1_ack_e10", ack_o[0], 1'b0);
    step(); step();                                   // E11, E12
    chk2("s1_idle_pair", {p_o[0], n_o[0]}, 2'b01);

    // Ping and alert together, then a ping during HsPh1
    do_reset();
    alert_req = 1; ping_event = 1; step();            // E0
    alert_req = 0; ping_event = 0;
    step(); step();                                   // E1, E2
    chk2("s2_pair_e2", {p_o[0], n_o[0]}, 2'b10);
    ping_event = 1; step(); ping_event = 0;           // E3
    ack_level = 1; step();                            // E4
    ack_level = 0; step();                            // E5
    step();                                           // E6
    chk1("s2_ack_e6", ack_o[0], 1'b1);
    chk1("s2_pend_e6", pend_o[0], 1'b0);
    step(); step();                                   // E7, E8
    chk2("s2_pair_e8", {p_o[0], n_o[0]}, 2'b01);
    step();                                           // E9
    chk2("s2_second_hs", {p_o[0], n_o[0]}, 2'b10);
    ack_level = 1; step(); ack_level = 0; step();     // E10, E11
    step();                                           // E12
    chk1("s2_ping_only_noack", ack_o[0], 1'b0);

    // Fatal alert: re-sent after every ack
    do_reset();
    alert_req = 1; step(); alert_req = 0;             // E0
    step(); step();                                   // E1, E2
    chk2("s3_f_pair_e2", {p_o[1], n_o[1]}, 2'b10);
    ack_level = 1; step();                            // E3
    ack_level = 0; step();                            // E4
    step();                                           // E5
    chk1("s3_f_ack", ack_o[1], 1'b1);
    chk1("s3_f_pend", pend_o[1], 1'b1);
    chk1("s3_nf_pend", pend_o[0], 1'b0);
    step(); step(); step();                           // E6..E8
    chk2("s3_f_resend", {p_o[1], n_o[1]}, 2'b10);
    chk2("s3_nf_quiet", {p_o[0], n_o[0]}, 2'b01);
    ack_level = 1; step(); ack_level = 0; step(); step(); step();
    chk1("s3_f_pend_still", pend_o[1], 1'b1);
    rst_i = 1; #2;
    chk1("s3_f_pend_rst", pend_o[1], 1'b0);

    // Test alert on the fatal instance is not sticky
    do_reset();
    alert_test = 1; step(); alert_test = 0;           // E0
    step(); step();                                   // E1, E2
    ack_level = 1; step();                            // E3
    ack_level = 0; step();                            // E4
    step();                                           // E5
    chk1("s4_test_ack", ack_o[1], 1'b1);
    chk1("s4_test_not_sticky", pend_o[1], 1'b0);

    // Signal-integrity error on the ack pair during HsPh2
    do_reset();
    alert_req = 1; step(); alert_req = 0;             // E0
    step(); step();                                   // E1, E2
    ack_level = 1; step();                            // E3
    step();                                           // E4
    chk2("s5_pair_e4", {p_o[0], n_o[0]}, 2'b01);
    ack_sigint = 1; step();                           // E5
    step();                                           // E6
    chk2("s5_sig_e6", {p_o[0], n_o[0]}, 2'b11);
    chk1("s5_integ_e6", integ_o[0], 1'b1);
    step();                                           // E7
    chk2("s5_sig_e7", {p_o[0], n_o[0]}, 2'b00);
    step();                                           // E8
    chk2("s5_sig_e8", {p_o[0], n_o[0]}, 2'b11);
    chk1("s5_pend_kept", pend_o[0], 1'b1);
    ack_sigint = 0; ack_level = 0; step();            // E9
    chk2("s5_sig_e9", {p_o[0], n_o[0]}, 2'b00);
    step();                                           // E10
    chk2("s5_restore", {p_o[0], n_o[0]}, 2'b01);
    chk1("s5_integ_clr", integ_o[0], 1'b0);
    step(); step(); step();                           // E11..E13
    chk2("s5_retx", {p_o[0], n_o[0]}, 2'b10);

    // PingOn=0 ignores pings and ping sigint
    do_reset();
    for (int i = 0; i < 6; i++) begin
      ping_event = ~ping_event;
      step();
      chk2("s6_np_pair", {p_o[2], n_o[2]}, 2'b01);
    end
    ping_event = 0;
    chk2("s6_pingon_hs", {p_o[0], n_o[0]}, 2'b10);
    ping_sigint = 1; step(); step();
    chk1("s6_np_integ", integ_o[2], 1'b0);
    chk1("s6_pingon_integ", integ_o[0], 1'b1);
    ping_sigint = 0;

    // Asynchronous reset mid-HsPh1
    do_reset();
    alert_req = 1; step(); alert_req = 0;             // E0
    step(); step();                                   // E1, E2
    chk2("s7_pair_e2", {p_o[0], n_o[0]}, 2'b10);
    #3 rst_i = 1; #1;
    chk2("s7_async_pair", {p_o[0], n_o[0]}, 2'b01);
    chk1("s7_async_pend", pend_o[0], 1'b0);
    step(); step();
    rst_i = 0;
    ack_level = 1; step(); ack_level = 0; step(); step(); step();
    chk1("s7_no_ack", ack_o[0], 1'b0);
    chk2("s7_quiet_pair", {p_o[0], n_o[0]}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
